// File: rtl/spike_label_fifo_if.sv
// Classifier-result input and show-ahead readout handshake of spike_label_fifo.
interface spike_label_fifo_if #(
    parameter int unsigned LW       = 2,
    parameter int unsigned TS_WIDTH = 16
);
    logic                in_valid;
    logic [LW-1:0]       in_level;
    logic [LW-1:0]       in_path;
    logic                out_valid;
    logic                out_ready;
    logic [TS_WIDTH-1:0] out_timestamp;
    logic [LW-1:0]       out_level;
    logic [LW-1:0]       out_path;

    modport slave (
        input  in_valid, in_level, in_path, out_ready,
        output out_valid, out_timestamp, out_level, out_path
    );

    modport master (
        output in_valid, in_level, in_path, out_ready,
        input  out_valid, out_timestamp, out_level, out_path
    );
endinterface

// File: rtl/spike_label_fifo.sv
// Timestamps classifier results and buffers them in a show-ahead FIFO;
// results arriving while full are dropped and counted, never stalling the source.
module spike_label_fifo #(
    parameter int unsigned FEATURES   = 3,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TS_WIDTH   = 16,
    parameter int unsigned DROP_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    spike_label_fifo_if.slave       bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic [DROP_WIDTH-1:0]   drop_count,
    input  logic                    clear_overflow
);
    localparam int unsigned LW = $clog2(FEATURES);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = TS_WIDTH + 2 * LW;
    localparam logic [DROP_WIDTH-1:0] DROP_MAX = {DROP_WIDTH{1'b1}};

    logic [TS_WIDTH-1:0] ts;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [WW-1:0]       mem [DEPTH];
    logic [WW-1:0]       head_word;
    logic [CW-1:0]       count_next;
    logic                pop_c;
    logic                push_c;
    logic                drop_c;

    always_comb begin
        pop_c      = !empty && bus.out_ready;
        push_c     = bus.in_valid && (!full || pop_c);
        drop_c     = bus.in_valid && full && !pop_c;
        count_next = count + CW'(push_c) - CW'(pop_c);
    end

    // Free-running sample counter; captures see the pre-increment value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts <= '0;
        else if (tick) ts <= ts + TS_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= {ts, bus.in_level, bus.in_path};
    end

    // Pointers and occupancy flags all move on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // A drop in the same cycle as a clear wins and restarts the count at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop_c) begin
            overflow <= 1'b1;
            if (clear_overflow)         drop_count <= DROP_WIDTH'(1);
            else if (drop_count != DROP_MAX) drop_count <= drop_count + DROP_WIDTH'(1);
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    // Head data is masked while empty so stale storage never reaches the port.
    assign head_word         = mem[rd_ptr];
    assign bus.out_valid     = !empty;
    assign bus.out_timestamp = empty ? '0 : head_word[WW-1 -: TS_WIDTH];
    assign bus.out_level     = empty ? '0 : head_word[2*LW-1 -: LW];
    assign bus.out_path      = empty ? '0 : head_word[LW-1:0];
endmodule

// File: doc/spike_label_fifo.md
Name: spike_label_fifo

Overview:
- Sits directly downstream of the decision-tree classifier and consumes its per-spike result pulse (level, path, valid).
- Stamps each classified spike with a free-running sample-count timestamp and buffers the result in a show-ahead FIFO.
- Hands results to the readout or host side over a valid/ready handshake.
- Drops and counts results that arrive while the buffer is full; nothing stalls the classifier.

Parameters:
- FEATURES, 3: classifier feature count. Label width LW = $clog2(FEATURES). Must be >= 2.
- DEPTH, 8: FIFO entries. Must be a power of two, >= 2.
- TS_WIDTH, 16: timestamp counter width.
- DROP_WIDTH, 8: width of the saturating drop counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  one clock; reset is asynchronous and active-low.
- tick  in  1  sample strobe; advances the timestamp counter by 1.
- in_valid  in  1  classifier out_valid; one-cycle result pulse.
- in_level  in  LW  classifier level.
- in_path  in  LW  classifier path.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_timestamp  out  TS_WIDTH  timestamp of the head entry.
- out_level  out  LW  level of the head entry.
- out_path  out  LW  path of the head entry.
- count  out  $clog2(DEPTH)+1  occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky; set when at least one result has been dropped.
- drop_count  out  DROP_WIDTH  dropped results, saturating.
- clear_overflow  in  1  clears overflow and drop_count.

Behaviour:
- Reset (reset low, asynchronous):
  - Timestamp counter, read/write pointers, count, drop_count and overflow all go to 0.
  - out_valid=0, empty=1, full=0, out_* data=0.
  - Reset mid-operation discards all entries. No output may glitch to 1 during reset.
- Timestamp:
  - TS counter increments on each clk edge with tick=1 and wraps from 2^TS_WIDTH-1 to 0.
  - A captured timestamp is the counter value before any same-cycle increment.
- Push:
  - push = in_valid && (!full || pop).
  - Stored word is {ts, in_level, in_path}.
  - in_valid has no backpressure; the producer never waits.
- Pop: pop = out_valid && out_ready. out_ready while empty has no effect.
- Show-ahead read:
  - out_valid = !empty. out_* present the head entry combinationally from storage or registered head.
  - out_* hold stable while out_valid=1 and out_ready=0.
  - Write-to-read latency: entry pushed at edge N appears on out_* with out_valid=1 after edge N, i.e. visible in cycle N+1. No same-cycle bypass.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full and the push into an empty FIFO.
  - Count is unchanged, except when empty: then only the push happens and count becomes 1. Pop is impossible when empty.
- Pointers are LW-independent, $clog2(DEPTH) bits, and wrap naturally.
- Drop:
  - drop = in_valid && full && !pop.
  - On drop: overflow<=1 and drop_count increments, saturating at 2^DROP_WIDTH-1. FIFO contents are unchanged.
- clear_overflow:
  - With no drop in the same cycle: overflow<=0, drop_count<=0.
  - With a drop in the same cycle: overflow<=1, drop_count<=1 (the new event wins).
- count, full and empty are registered-consistent: all three update on the same edge.

Test Plan:
- Reset, then tick 5 times, then in_valid with level=1 path=2 and out_ready=0 → next cycle out_valid=1, out_timestamp=5, out_level=1, out_path=2, count=1; outputs held over 3 further cycles.
- Push 8 results with ts 0..7 with out_ready=0 → full=1, count=8; a 9th in_valid gives overflow=1, drop_count=1, count=8; draining yields ts 0..7 in order, then empty=1.
- When full, in_valid together with out_ready=1 → the oldest entry (ts 0) pops, the new entry is accepted, count stays 8, drop_count unchanged; the new entry emerges last.
- tick and in_valid in the same cycle with counter=0xFFFF → stored timestamp=0xFFFF; the counter reads 0 afterwards; the next capture gets 0.
- With full and out_ready=0, issue 300 drops → drop_count=255 (saturated); clear_overflow coinciding with one more drop → overflow=1, drop_count=1; a clear with no drop → both 0.
- Assert reset for 1 cycle mid-stream with count=5 and asynchronous to clk → out_valid=0, empty=1, count=0 immediately; after release the next push appears with the correctly reset timestamp.
